// File: rtl/simpleio_bus_arbiter.sv
// Two-master arbiter for the simpleio register port. Each access produces exactly
// one io_cs strobe, and the peripheral's registered read data goes back to the granted master.
module simpleio_bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0  // 1: m0 wins ties; 0: alternate between masters
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_rw,
    input  logic [3:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic [7:0] m0_rdata,
    output logic       m0_ack,
    input  logic       m1_req,
    input  logic       m1_rw,
    input  logic [3:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic [7:0] m1_rdata,
    output logic       m1_ack,
    output logic       io_cs,
    output logic       io_rw,
    output logic [3:0] io_addr,
    output logic [7:0] io_di,
    input  logic [7:0] io_do,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t     r_state,    w_state_next;
    logic       r_grant,    w_grant_next;
    logic       r_io_cs,    w_io_cs_next;
    logic       r_io_rw,    w_io_rw_next;
    logic [3:0] r_io_addr,  w_io_addr_next;
    logic [7:0] r_io_di,    w_io_di_next;
    logic       r_m0_ack,   w_m0_ack_next;
    logic       r_m1_ack,   w_m1_ack_next;
    logic [7:0] r_m0_rdata, w_m0_rdata_next;
    logic [7:0] r_m1_rdata, w_m1_rdata_next;
    logic       r_busy,     w_busy_next;

    logic       w_win;
    logic       w_sel_rw;
    logic [3:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    // A tie goes to m0 in fixed mode, otherwise to the master that was not granted last time.
    assign w_win       = (m0_req & m1_req) ? (FIXED_PRIO ? 1'b0 : ~r_grant) : m1_req;
    assign w_sel_rw    = w_win ? m1_rw    : m0_rw;
    assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_io_cs_next    = r_io_cs;
        w_io_rw_next    = r_io_rw;
        w_io_addr_next  = r_io_addr;
        w_io_di_next    = r_io_di;
        w_m0_ack_next   = r_m0_ack;
        w_m1_ack_next   = r_m1_ack;
        w_m0_rdata_next = r_m0_rdata;
        w_m1_rdata_next = r_m1_rdata;

        case (r_state)
            IDLE: begin
                if (m0_req | m1_req) begin
                    w_grant_next   = w_win;
                    w_io_rw_next   = w_sel_rw;
                    w_io_addr_next = w_sel_addr;
                    w_io_di_next   = w_sel_rw ? 8'h00 : w_sel_wdata;
                    w_io_cs_next   = 1'b1;
                    w_state_next   = ISSUE;
                end
            end
            ISSUE: begin
                w_io_cs_next = 1'b0;
                w_state_next = CAPTURE;
            end
            CAPTURE: begin
                // The peripheral registered DO on the ISSUE edge, so it is valid here.
                if (r_io_rw) begin
                    if (r_grant) w_m1_rdata_next = io_do;
                    else         w_m0_rdata_next = io_do;
                end
                w_m0_ack_next = ~r_grant;
                w_m1_ack_next = r_grant;
                w_state_next  = DONE;
            end
            DONE: begin
                w_m0_ack_next = 1'b0;
                w_m1_ack_next = 1'b0;
                w_io_rw_next  = 1'b1;
                w_state_next  = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= 1'b1;
            r_io_cs    <= 1'b0;
            r_io_rw    <= 1'b1;
            r_io_addr  <= 4'h0;
            r_io_di    <= 8'h00;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= 8'h00;
            r_m1_rdata <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_io_cs    <= w_io_cs_next;
            r_io_rw    <= w_io_rw_next;
            r_io_addr  <= w_io_addr_next;
            r_io_di    <= w_io_di_next;
            r_m0_ack   <= w_m0_ack_next;
            r_m1_ack   <= w_m1_ack_next;
            r_m0_rdata <= w_m0_rdata_next;
            r_m1_rdata <= w_m1_rdata_next;
            r_busy     <= w_busy_next;
        end
    end

    assign io_cs    = r_io_cs;
    assign io_rw    = r_io_rw;
    assign io_addr  = r_io_addr;
    assign io_di    = r_io_di;
    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign busy     = r_busy;
    assign grant    = r_grant;

endmodule

// File: doc/simpleio_bus_arbiter.md
Name: simpleio_bus_arbiter

Overview:
- Shares the simpleio register port (4-bit address, 8-bit data, registered read data) between two bus masters: CPU side (m0) and a debug/DMA side (m1).
- Each master issues one register access through a req/ack handshake.
- The arbiter serialises accesses and drives exactly one io_cs strobe per access, because reads have side effects (reading UART DATA pops RX).
- It captures the peripheral's registered read data and returns it to the granted master.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0 and m1; 1 = m0 always wins on simultaneous requests.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 access request; held until m0_ack
- m0_rw  in  1  1 = read, 0 = write; stable while m0_req
- m0_addr  in  4  register address
- m0_wdata  in  8  write data
- m0_rdata  out  8  read data; valid when m0_ack=1 for a read
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0, for master 1
- io_cs  out  1  chip select to peripheral; one cycle per access
- io_rw  out  1  to peripheral rw
- io_addr  out  4  to peripheral Address
- io_di  out  8  to peripheral DI
- io_do  in  8  peripheral DO; registered by the peripheral on the edge where it samples io_cs=1 with io_rw=1
- busy  out  1  1 whenever state != IDLE
- grant  out  1  index of the current or last granted master

Behaviour:
- All outputs are registered.
- Reset values (asynchronous):
  - io_cs=0, io_rw=1, io_addr=0, io_di=0
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0
  - busy=0, grant=1, so m0 wins the first contention in round-robin mode
  - state=IDLE
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any req=1 at the edge, select the winner:
    - only one requesting: that master
    - both requesting, FIXED_PRIO=1: m0
    - both requesting, FIXED_PRIO=0: the master != grant
  - At that edge, register grant, io_rw, io_addr and io_di (io_di=wdata on writes, 0 on reads), set io_cs=1, and go to ISSUE.
- ISSUE:
  - io_cs is high for exactly this one cycle.
  - At the edge, set io_cs=0 and go to CAPTURE.
  - io_rw, io_addr and io_di hold their values.
- CAPTURE:
  - The peripheral's DO is now valid.
  - At the edge, if it is a read, load the granted master's rdata with io_do.
  - Pulse the granted master's ack=1 and go to DONE.
- DONE:
  - ack is high for this cycle only.
  - At the edge, clear ack, set io_rw=1 and go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge E0 -> ack high in the cycle after E2 (3 cycles).
  - Reads and writes have identical latency.
  - Maximum throughput is one access per 4 cycles.
- Handshake rules:
  - A master must deassert req at the first edge after it sees ack.
  - A req still high when IDLE is re-entered is a new access.
- Non-granted master: its req stays pending with no ack and no state change until it is granted.
- Round-robin check: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- The arbiter never overlaps accesses and never asserts io_cs in two consecutive cycles.
- Request dropped after grant: the access still completes. io_cs was already issued, so the ack still pulses and rdata still updates.
- The non-granted master's rdata is never modified.
- Request changes after grant: m*_rw, addr and wdata changes are ignored, because they were latched in IDLE.
- Reset mid-access:
  - Immediate return to reset values.
  - If io_cs was high it drops asynchronously.
  - No ack is issued for the aborted access.

Test Plan:
- m0 write: addr 0x0, data 0xA5 -> io_cs high exactly one cycle with io_rw=0, io_addr=0, io_di=0xA5; m0_ack pulses 3 cycles after the req sample; m1_ack stays 0.
- m1 read: addr 0x2; peripheral model returns 0x3C one cycle after cs -> m1_rdata=0x3C while m1_ack=1; m0_rdata unchanged at 0.
- Simultaneous m0 and m1 read requests held for 4 accesses, FIXED_PRIO=0 -> grant order m0, m1, m0, m1; io_cs pulses separated by exactly 4 cycles; each ack is matched to the correct master.
- Same stimulus with FIXED_PRIO=1, m0 held continuously -> m1 is never granted until m0 drops req; then m1 is granted on the next IDLE.
- Read of addr 0x8 with req dropped during ISSUE -> exactly one io_cs pulse (the RX pop counter in the model increments by 1); m0_ack still pulses.
- rst asserted during ISSUE -> io_cs falls in the same cycle; no ack; after release, first contention is granted to m0.
